npc_mc_sequencer: RTL and testbench

- Multi-cycle replacement for the single-cycle datapath sequencing in the NPC top.
- Owns the PC and instruction register, and sequences fetch → execute → memory → writeback.
- Fetch and data memory are reached over valid/ready request plus response-valid handshakes, so variable-latency IFU/LSU can be attached.
- Decode stays combinational in the existing IDU/ALU/BSU, driven from this block's inst register; this block only gates strobes, commits, traps and halts.

---
 rtl/npc_pkg.sv | 25 ++
 rtl/npc_wait_timer.sv | 28 ++
 rtl/npc_mc_sequencer.sv | 164 ++++++++++++++++
 tb/tb_npc_mc_sequencer.sv | 366 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/npc_pkg.sv
// Shared types and constants for the multi-cycle NPC sequencer and its helpers.
package npc_pkg;

  localparam logic [31:0] DEFAULT_RESET_PC = 32'h8000_0000;

  localparam logic [1:0] ERR_EBREAK   = 2'd0;
  localparam logic [1:0] ERR_TIMEOUT  = 2'd1;
  localparam logic [1:0] ERR_MISALIGN = 2'd2;

  typedef enum logic [2:0] {
    FETCH_REQ,
    FETCH_WAIT,
    EXEC,
    MEM_REQ,
    MEM_WAIT,
    WB,
    HALT
  } state_t;

  // States that wait on an external handshake and are guarded by the timeout.
  function automatic logic is_handshake(input state_t s);
    return (s == FETCH_REQ) || (s == FETCH_WAIT) || (s == MEM_REQ) || (s == MEM_WAIT);
  endfunction

endpackage

// File: rtl/npc_wait_timer.sv
// Clear/enable wait counter; expire is high during the limit-th enabled cycle since clear.
module npc_wait_timer #(
  parameter int unsigned W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clear,
  input  logic         enable,
  input  logic [W-1:0] limit,
  output logic         expire
);

  logic [W-1:0] count;

  always_ff @(posedge clk) begin
    if (!rst) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable) begin
      count <= count + W'(1);
    end
  end

  // A zero limit disables expiry entirely.
  assign expire = enable && (limit != '0) && (count == limit - W'(1));

endmodule

// File: rtl/npc_mc_sequencer.sv
// Multi-cycle fetch/exec/mem/writeback sequencer owning PC, IR, load data and retire count.
module npc_mc_sequencer
  import npc_pkg::*;
#(
  parameter int unsigned     XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = XLEN'(DEFAULT_RESET_PC),
  parameter int unsigned     TIMEOUT  = 1024,
  parameter int unsigned     CNT_W    = 64
) (
  input  logic             clk,
  input  logic             rst,
  output logic             ifu_req_valid,
  input  logic             ifu_req_ready,
  output logic [XLEN-1:0]  ifu_addr,
  input  logic             ifu_rsp_valid,
  input  logic [31:0]      ifu_rsp_inst,
  output logic             lsu_req_valid,
  input  logic             lsu_req_ready,
  input  logic             lsu_rsp_valid,
  input  logic [XLEN-1:0]  lsu_rsp_data,
  input  logic             dec_is_load,
  input  logic             dec_is_store,
  input  logic             dec_wb_en,
  input  logic             dec_csr_we,
  input  logic             dec_jump_en,
  input  logic [XLEN-1:0]  dec_jump_pc,
  input  logic             dec_ebreak,
  output logic [XLEN-1:0]  pc,
  output logic [31:0]      inst,
  output logic [XLEN-1:0]  mem_rdata,
  output logic             rf_we,
  output logic             csr_we,
  output logic             commit,
  output logic [CNT_W-1:0] retired,
  output logic             halted,
  output logic [1:0]       err
);

  state_t     state_q;
  state_t     state_d;
  logic [1:0] err_d;
  logic       timer_clear;
  logic       timer_enable;
  logic       expire;

  assign timer_enable = is_handshake(state_q);
  assign timer_clear  = (state_d != state_q);

  npc_wait_timer #(.W(32)) u_wait_timer (
    .clk    (clk),
    .rst    (rst),
    .clear  (timer_clear),
    .enable (timer_enable),
    .limit  (TIMEOUT),
    .expire (expire)
  );

  always_comb begin
    state_d       = state_q;
    err_d         = err;
    ifu_req_valid = 1'b0;
    lsu_req_valid = 1'b0;
    rf_we         = 1'b0;
    csr_we        = 1'b0;
    commit        = 1'b0;
    unique case (state_q)
      FETCH_REQ: begin
        ifu_req_valid = 1'b1;
        if (ifu_req_ready) begin
          state_d = FETCH_WAIT;
        end else if (expire) begin
          state_d = HALT;
          err_d   = ERR_TIMEOUT;
        end
      end
      FETCH_WAIT: begin
        if (ifu_rsp_valid) begin
          state_d = EXEC;
        end else if (expire) begin
          state_d = HALT;
          err_d   = ERR_TIMEOUT;
        end
      end
      EXEC: begin
        if (dec_ebreak) begin
          state_d = HALT;
          err_d   = ERR_EBREAK;
        end else if (dec_jump_en && (dec_jump_pc[1:0] != 2'b00)) begin
          state_d = HALT;
          err_d   = ERR_MISALIGN;
        end else if (dec_is_load || dec_is_store) begin
          state_d = MEM_REQ;
        end else begin
          state_d = WB;
        end
      end
      MEM_REQ: begin
        lsu_req_valid = 1'b1;
        if (lsu_req_ready) begin
          state_d = MEM_WAIT;
        end else if (expire) begin
          state_d = HALT;
          err_d   = ERR_TIMEOUT;
        end
      end
      MEM_WAIT: begin
        if (lsu_rsp_valid) begin
          state_d = WB;
        end else if (expire) begin
          state_d = HALT;
          err_d   = ERR_TIMEOUT;
        end
      end
      WB: begin
        rf_we   = dec_wb_en;
        csr_we  = dec_csr_we;
        commit  = 1'b1;
        state_d = FETCH_REQ;
      end
      HALT: begin
        state_d = HALT;
      end
      default: begin
        state_d = HALT;
      end
    endcase
    // Keep every request and strobe quiet while reset is held, whatever state is still registered.
    if (!rst) begin
      ifu_req_valid = 1'b0;
      lsu_req_valid = 1'b0;
      rf_we         = 1'b0;
      csr_we        = 1'b0;
      commit        = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= FETCH_REQ;
      pc        <= RESET_PC;
      inst      <= '0;
      mem_rdata <= '0;
      retired   <= '0;
      err       <= ERR_EBREAK;
    end else begin
      state_q <= state_d;
      err     <= err_d;
      if ((state_q == FETCH_WAIT) && ifu_rsp_valid) begin
        inst <= ifu_rsp_inst;
      end
      if ((state_q == MEM_WAIT) && lsu_rsp_valid && dec_is_load) begin
        mem_rdata <= lsu_rsp_data;
      end
      if (state_q == WB) begin
        pc      <= dec_jump_en ? dec_jump_pc : pc + XLEN'(4);
        retired <= retired + CNT_W'(1);
      end
    end
  end

  assign ifu_addr = pc;
  assign halted   = (state_q == HALT);

endmodule

// File: tb/tb_npc_mc_sequencer.sv
// Scoreboard bench: IFU/LSU/decode environment, reference retire model, decoupled commit monitor.
module tb_npc_mc_sequencer;

  localparam logic [31:0] RST_PC   = 32'h8000_0000;
  localparam logic [31:0] EBREAK_W = 32'h0010_0073;
  localparam logic [31:0] ADDI_W   = 32'h0000_0004;
  localparam logic [31:0] LOAD_W   = 32'h0000_0001;

  // Toy encoding: [1:0] 0 alu,1 load,2 store,3 jump; [2] wb; [3] csr; jump target {8,[31:6],[5:4]}.
  typedef struct packed {
    logic        ld;
    logic        st;
    logic        wb;
    logic        csr;
    logic        jmp;
    logic        ebk;
    logic [31:0] jpc;
  } dec_t;

  typedef struct {
    logic [31:0] pc;
    logic        rf_we;
    logic        csr_we;
    logic [31:0] rdata;
    logic [63:0] ret;
  } exp_t;

  function automatic dec_t decode(input logic [31:0] w);
    dec_t d;
    d.ebk = (w == EBREAK_W);
    d.ld  = (w[1:0] == 2'd1);
    d.st  = (w[1:0] == 2'd2);
    d.jmp = (w[1:0] == 2'd3);
    d.wb  = w[2] | d.ld;
    d.csr = w[3];
    d.jpc = {4'h8, w[31:6], w[5:4]};
    return d;
  endfunction

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        ifu_req_valid, ifu_req_ready, ifu_rsp_valid;
  logic [31:0] ifu_addr, ifu_rsp_inst;
  logic        lsu_req_valid, lsu_req_ready, lsu_rsp_valid;
  logic [31:0] lsu_rsp_data;
  logic        dec_is_load, dec_is_store, dec_wb_en, dec_csr_we, dec_jump_en, dec_ebreak;
  logic [31:0] dec_jump_pc;
  logic [31:0] pc, inst, mem_rdata;
  logic        rf_we, csr_we, commit, halted;
  logic [63:0] retired;
  logic [1:0]  err;
  dec_t        dcd;

  always #5 clk = ~clk;

  assign dcd          = decode(inst);
  assign dec_is_load  = dcd.ld;
  assign dec_is_store = dcd.st;
  assign dec_wb_en    = dcd.wb;
  assign dec_csr_we   = dcd.csr;
  assign dec_jump_en  = dcd.jmp;
  assign dec_jump_pc  = dcd.jpc;
  assign dec_ebreak   = dcd.ebk;

  npc_mc_sequencer #(.TIMEOUT(8)) dut (
    .clk(clk), .rst(rst),
    .ifu_req_valid(ifu_req_valid), .ifu_req_ready(ifu_req_ready), .ifu_addr(ifu_addr),
    .ifu_rsp_valid(ifu_rsp_valid), .ifu_rsp_inst(ifu_rsp_inst),
    .lsu_req_valid(lsu_req_valid), .lsu_req_ready(lsu_req_ready),
    .lsu_rsp_valid(lsu_rsp_valid), .lsu_rsp_data(lsu_rsp_data),
    .dec_is_load(dec_is_load), .dec_is_store(dec_is_store), .dec_wb_en(dec_wb_en),
    .dec_csr_we(dec_csr_we), .dec_jump_en(dec_jump_en), .dec_jump_pc(dec_jump_pc),
    .dec_ebreak(dec_ebreak), .pc(pc), .inst(inst), .mem_rdata(mem_rdata),
    .rf_we(rf_we), .csr_we(csr_we), .commit(commit), .retired(retired),
    .halted(halted), .err(err)
  );

  int checks   = 0;
  int failures = 0;

  exp_t        exp_q[$];
  logic [31:0] inst_src[$];
  logic [31:0] ld_src[$];
  logic [31:0] fetch_q[$];
  logic [31:0] m_pc, m_rdata;
  logic [63:0] m_ret;

  int ifu_rd = 0, ifu_sd = 0, lsu_rd = 0, lsu_sd = 0;
  bit rand_lat = 1'b0, ifu_mute = 1'b0, lsu_manual = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
    checks++;
    if (act !== expv) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, expv);
    end
  endtask

  function automatic int pick(input int fixed);
    return rand_lat ? int'($urandom_range(0, 4)) : fixed;
  endfunction

  function automatic logic [31:0] rand_inst();
    logic [31:0] w;
    w      = $urandom;
    w[1:0] = 2'($urandom_range(0, 3));
    if (w[1:0] == 2'd3) w[5:4] = 2'd0;
    return w;
  endfunction

  function automatic logic [31:0] mk_jump(input logic [31:0] target, input logic wb);
    return {target[27:2], target[1:0], 1'b0, wb, 2'b11};
  endfunction

  // Reference model: architectural effect of one instruction, pushed as stimulus is issued.
  task automatic gen(input logic [31:0] w, input logic [31:0] data);
    dec_t d;
    exp_t e;
    d = decode(w);
    fetch_q.push_back(m_pc);
    inst_src.push_back(w);
    if (d.ebk || (d.jmp && d.jpc[1:0] != 2'b00)) return;
    if (d.ld || d.st) ld_src.push_back(data);
    if (d.ld) m_rdata = data;
    e.pc = m_pc; e.rf_we = d.wb; e.csr_we = d.csr; e.rdata = m_rdata; e.ret = m_ret;
    exp_q.push_back(e);
    m_ret = m_ret + 64'd1;
    m_pc  = d.jmp ? d.jpc : m_pc + 32'd4;
  endtask

  // IFU model
  initial begin
    int ph, cnt;
    ph = 0; cnt = 0;
    ifu_req_ready = 1'b0; ifu_rsp_valid = 1'b0; ifu_rsp_inst = '0;
    forever begin
      @(negedge clk);
      ifu_req_ready = 1'b0;
      ifu_rsp_valid = 1'b0;
      if (!rst) begin
        ph = 0;
      end else if (ph == 2) begin
        if (cnt > 0) cnt--;
        else if (!ifu_mute && inst_src.size() > 0) begin
          ifu_rsp_valid = 1'b1;
          ifu_rsp_inst  = inst_src.pop_front();
          ph = 0;
        end
      end else begin
        if (ph == 0 && ifu_req_valid) begin ph = 1; cnt = pick(ifu_rd); end
        if (ph == 1) begin
          if (cnt > 0) cnt--;
          else begin
            ifu_req_ready = 1'b1;
            if (fetch_q.size() > 0) chk("fetch_addr", 64'(ifu_addr), 64'(fetch_q.pop_front()));
            ph = 2; cnt = pick(ifu_sd);
          end
        end
      end
    end
  end

  // LSU model
  initial begin
    int ph, cnt;
    ph = 0; cnt = 0;
    lsu_req_ready = 1'b0; lsu_rsp_valid = 1'b0; lsu_rsp_data = '0;
    forever begin
      @(negedge clk);
      if (lsu_manual) begin ph = 0; continue; end
      lsu_req_ready = 1'b0;
      lsu_rsp_valid = 1'b0;
      if (!rst) begin
        ph = 0;
      end else if (ph == 2) begin
        if (cnt > 0) cnt--;
        else if (ld_src.size() > 0) begin
          lsu_rsp_valid = 1'b1;
          lsu_rsp_data  = ld_src.pop_front();
          ph = 0;
        end
      end else begin
        if (ph == 0 && lsu_req_valid) begin ph = 1; cnt = pick(lsu_rd); end
        if (ph == 1) begin
          if (cnt > 0) cnt--;
          else begin lsu_req_ready = 1'b1; ph = 2; cnt = pick(lsu_sd); end
        end
      end
    end
  end

  // Commit monitor
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst) begin
        if ((rf_we || csr_we) && !commit) begin
          chk("strobe_outside_wb", 64'({rf_we, csr_we}), 64'd0);
        end
        if (commit) begin
          if (exp_q.size() == 0) begin
            checks++; failures++;
            $display("FAIL unexpected_commit: got commit at pc 0x%0h expected none", pc);
          end else begin
            e = exp_q.pop_front();
            chk("commit_pc", 64'(pc), 64'(e.pc));
            chk("commit_rf_we", 64'(rf_we), 64'(e.rf_we));
            chk("commit_csr_we", 64'(csr_we), 64'(e.csr_we));
            chk("commit_mem_rdata", 64'(mem_rdata), 64'(e.rdata));
            chk("commit_retired", retired, e.ret);
          end
        end
      end
    end
  end

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b0;
    exp_q.delete(); inst_src.delete(); ld_src.delete(); fetch_q.delete();
    m_pc = RST_PC; m_ret = '0; m_rdata = '0;
    ifu_rd = 0; ifu_sd = 0; lsu_rd = 0; lsu_sd = 0;
    rand_lat = 1'b0; ifu_mute = 1'b0; lsu_manual = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
  endtask

  task automatic wait_commit(output int cyc, input int budget);
    cyc = 0;
    while (cyc < budget) begin
      @(negedge clk);
      cyc++;
      if (commit) return;
    end
    chk("commit_timeout", 64'd0, 64'd1);
  endtask

  task automatic wait_halt(output int cyc, input int budget);
    cyc = 0;
    while (cyc < budget) begin
      @(negedge clk);
      cyc++;
      if (halted) return;
    end
    chk("halt_timeout", 64'd0, 64'd1);
  endtask

  initial begin
    #1_000_000;
    failures++;
    $display("FAIL watchdog: got no finish expected finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1);
  end

  initial begin
    int cyc, vcount;
    do_reset();
    @(negedge clk);
    chk("rst_pc", 64'(pc), 64'(RST_PC));
    chk("rst_inst", 64'(inst), 64'd0);
    chk("rst_mem_rdata", 64'(mem_rdata), 64'd0);
    chk("rst_retired", retired, 64'd0);
    chk("rst_halted", 64'(halted), 64'd0);
    chk("rst_err", 64'(err), 64'd0);
    chk("rst_ifu_valid", 64'(ifu_req_valid), 64'd1);
    chk("rst_strobes", 64'({lsu_req_valid, rf_we, csr_we, commit}), 64'd0);

    // zero-wait ALU instruction: commit in cycle 4
    do_reset();
    gen(ADDI_W, 32'd0);
    wait_commit(cyc, 20);
    chk("alu_latency", 64'(cyc), 64'd4);
    chk("alu_rf_we", 64'(rf_we), 64'd1);
    @(negedge clk);
    chk("alu_next_pc", 64'(pc), 64'h8000_0004);
    chk("alu_retired", retired, 64'd1);

    // load with slow LSU: 2-cycle accept, response 3 cycles later
    do_reset();
    lsu_rd = 2; lsu_sd = 3;
    gen(LOAD_W, 32'hDEAD_BEEF);
    wait_commit(cyc, 40);
    chk("load_latency", 64'(cyc), 64'd11);
    chk("load_data", 64'(mem_rdata), 64'hDEAD_BEEF);
    vcount = 1;
    repeat (10) begin @(negedge clk); if (rf_we) vcount++; end
    chk("load_rf_we_cycles", 64'(vcount), 64'd1);

    // taken branch then misaligned redirect
    do_reset();
    gen(mk_jump(32'h8000_0100, 1'b1), 32'd0);
    gen(ADDI_W, 32'd0);
    gen(mk_jump(32'h8000_0102, 1'b0), 32'd0);
    wait_halt(cyc, 100);
    chk("misalign_err", 64'(err), 64'd2);
    chk("misalign_retired", retired, m_ret);
    chk("misalign_pending", 64'(exp_q.size()), 64'd0);

    // ebreak as third instruction, then verify the halt is absorbing
    do_reset();
    rand_lat = 1'b1;
    gen(rand_inst(), $urandom);
    gen(rand_inst(), $urandom);
    gen(EBREAK_W, 32'd0);
    wait_halt(cyc, 200);
    chk("ebreak_err", 64'(err), 64'd0);
    chk("ebreak_retired", retired, 64'd2);
    vcount = 0;
    repeat (20) begin @(negedge clk); if (ifu_req_valid || !halted) vcount++; end
    chk("halt_no_fetch", 64'(vcount), 64'd0);
    chk("halt_pc_frozen", 64'(pc), 64'(m_pc));
    chk("halt_inst_frozen", 64'(inst), 64'(EBREAK_W));

    // randomized program with random handshake latencies
    do_reset();
    rand_lat = 1'b1;
    for (int i = 0; i < 60; i++) gen(rand_inst(), $urandom);
    gen(EBREAK_W, 32'd0);
    wait_halt(cyc, 3000);
    chk("rand_err", 64'(err), 64'd0);
    chk("rand_retired", retired, m_ret);
    chk("rand_pending", 64'(exp_q.size()), 64'd0);

    // IFU never responds: accepted at end of cycle 1, halt 8 cycles later
    do_reset();
    ifu_mute = 1'b1;
    wait_halt(cyc, 40);
    chk("timeout_cycle", 64'(cyc), 64'd10);
    chk("timeout_err", 64'(err), 64'd1);
    chk("timeout_retired", retired, 64'd0);

    // reset while in MEM_WAIT; a late response must be ignored
    do_reset();
    lsu_manual = 1'b1;
    gen(LOAD_W, 32'h0);
    cyc = 0;
    while (cyc < 30 && !lsu_req_valid) begin @(negedge clk); cyc++; end
    chk("midreset_reached_mem", 64'(lsu_req_valid), 64'd1);
    lsu_req_ready = 1'b1;
    @(negedge clk);
    lsu_req_ready = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    exp_q.delete(); inst_src.delete(); ld_src.delete(); fetch_q.delete();
    m_pc = RST_PC; m_ret = '0; m_rdata = '0;
    @(posedge clk); #1 rst = 1'b1;
    @(negedge clk);
    chk("midreset_fetch_req", 64'(ifu_req_valid), 64'd1);
    chk("midreset_addr", 64'(ifu_addr), 64'(RST_PC));
    lsu_rsp_valid = 1'b1;
    lsu_rsp_data  = 32'h1234_5678;
    @(negedge clk);
    lsu_rsp_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("midreset_mem_rdata", 64'(mem_rdata), 64'd0);
    chk("midreset_pc", 64'(pc), 64'(RST_PC));
    chk("midreset_retired", retired, 64'd0);
    chk("midreset_lsu_idle", 64'(lsu_req_valid), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
